// File: rtl/fpro_mmio_arbiter.sv
// -----------------------------------------------------------------------------
// fpro_mmio_arbiter
// Two-master arbiter in front of the FPro MMIO bus. Master 0 is the CPU-side
// bridge and master 1 is a secondary master (DMA / self-test engine). Each
// access is a single registered beat: IDLE -> ISSUE -> DONE -> IDLE.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   mX_req/mX_wr/mX_addr/mX_wr_data
//                                request from master X, held until mX_gnt
//   mX_gnt                       1-cycle pulse, coincides with the bus cycle
//   mX_rd_data / mX_rd_valid     read data and its 1-cycle strobe
//   fp_mmio_cs/fp_rd/fp_wr       bus qualifiers, high only in ISSUE
//   fp_addr/fp_wr_data           bus address/data, hold last value
//   fp_rd_data                   slave read data, sampled at end of ISSUE
// -----------------------------------------------------------------------------
module fpro_mmio_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_rd_valid,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_rd_valid,
  output logic                  fp_mmio_cs,
  output logic                  fp_rd,
  output logic                  fp_wr,
  output logic [ADDR_WIDTH-1:0] fp_addr,
  output logic [DATA_WIDTH-1:0] fp_wr_data,
  input  logic [DATA_WIDTH-1:0] fp_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Winner selection: lone requester wins; on a tie either master 0 (fixed
  // priority) or the master that was not served last (round robin).
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last);
    logic w;
    if (req0 && req1) begin
      if (FIXED_PRIO != 32'sd0) begin
        w = 1'b0;
      end else begin
        w = ~last;
      end
    end else if (req1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  state_t                  state_r,      state_s;
  logic                    last_grant_r, last_grant_s;
  logic                    cs_r,         cs_s;
  logic                    rd_r,         rd_s;
  logic                    wr_r,         wr_s;
  logic [ADDR_WIDTH-1:0]   addr_r,       addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_r,    wr_data_s;
  logic                    gnt0_r,       gnt0_s;
  logic                    gnt1_r,       gnt1_s;
  logic [DATA_WIDTH-1:0]   rd_data0_r,   rd_data0_s;
  logic [DATA_WIDTH-1:0]   rd_data1_r,   rd_data1_s;
  logic                    rd_valid0_r,  rd_valid0_s;
  logic                    rd_valid1_r,  rd_valid1_s;
  logic                    winner_s;
  logic                    sel_wr_s;

  // Next-state and next-output logic; last_grant_r doubles as the owner of
  // the transaction in flight because it is updated on entry to ISSUE.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    cs_s         = 1'b0;
    rd_s         = 1'b0;
    wr_s         = 1'b0;
    addr_s       = addr_r;
    wr_data_s    = wr_data_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    rd_data0_s   = rd_data0_r;
    rd_data1_s   = rd_data1_r;
    rd_valid0_s  = 1'b0;
    rd_valid1_s  = 1'b0;
    winner_s     = 1'b0;
    sel_wr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          winner_s = pick_winner(m0_req, m1_req, last_grant_r);
          if (winner_s) begin
            sel_wr_s  = m1_wr;
            addr_s    = m1_addr;
            wr_data_s = m1_wr_data;
            gnt1_s    = 1'b1;
          end else begin
            sel_wr_s  = m0_wr;
            addr_s    = m0_addr;
            wr_data_s = m0_wr_data;
            gnt0_s    = 1'b1;
          end
          cs_s         = 1'b1;
          rd_s         = ~sel_wr_s;
          wr_s         = sel_wr_s;
          last_grant_s = winner_s;
          state_s      = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_DONE;
        // Slave data is combinational, so it is captured at the end of ISSUE.
        if (rd_r) begin
          if (last_grant_r) begin
            rd_data1_s  = fp_rd_data;
            rd_valid1_s = 1'b1;
          end else begin
            rd_data0_s  = fp_rd_data;
            rd_valid0_s = 1'b1;
          end
        end else begin
          rd_valid0_s = 1'b0;
          rd_valid1_s = 1'b0;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every strobe at once and points
  // the round-robin pointer at master 1 so master 0 is served first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      cs_r         <= 1'b0;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wr_data_r    <= {DATA_WIDTH{1'b0}};
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      rd_data0_r   <= {DATA_WIDTH{1'b0}};
      rd_data1_r   <= {DATA_WIDTH{1'b0}};
      rd_valid0_r  <= 1'b0;
      rd_valid1_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cs_r         <= cs_s;
      rd_r         <= rd_s;
      wr_r         <= wr_s;
      addr_r       <= addr_s;
      wr_data_r    <= wr_data_s;
      gnt0_r       <= gnt0_s;
      gnt1_r       <= gnt1_s;
      rd_data0_r   <= rd_data0_s;
      rd_data1_r   <= rd_data1_s;
      rd_valid0_r  <= rd_valid0_s;
      rd_valid1_r  <= rd_valid1_s;
    end
  end

  assign fp_mmio_cs  = cs_r;
  assign fp_rd       = rd_r;
  assign fp_wr       = wr_r;
  assign fp_addr     = addr_r;
  assign fp_wr_data  = wr_data_r;
  assign m0_gnt      = gnt0_r;
  assign m1_gnt      = gnt1_r;
  assign m0_rd_data  = rd_data0_r;
  assign m1_rd_data  = rd_data1_r;
  assign m0_rd_valid = rd_valid0_r;
  assign m1_rd_valid = rd_valid1_r;

endmodule

// File: tb/tb_fpro_mmio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpro_mmio_arbiter
// Self-checking bench for fpro_mmio_arbiter. Instance dut_a uses round-robin
// arbitration, dut_b fixed priority; both see the same master stimulus and
// each has its own slave model returning data derived from the bus address.
// -----------------------------------------------------------------------------
module tb_fpro_mmio_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wr_data = '0;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wr_data = '0;

  logic          m0_gnt_a, m0_rd_valid_a, m1_gnt_a, m1_rd_valid_a;
  logic [DW-1:0] m0_rd_data_a, m1_rd_data_a;
  logic          cs_a, rd_a, wr_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a, rdata_a;

  logic          m0_gnt_b, m0_rd_valid_b, m1_gnt_b, m1_rd_valid_b;
  logic [DW-1:0] m0_rd_data_b, m1_rd_data_b;
  logic          cs_b, rd_b, wr_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;
  int onehot_viol = 0;

  always #5 clk = ~clk;

  // Slave model: a few fixed locations, otherwise an address-derived pattern.
  function automatic logic [DW-1:0] slave_fn(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    case (a)
      21'h00020: d = 32'h1234_5678;
      21'h00005: d = 32'h0000_000A;
      21'h00006: d = 32'h0000_000B;
      default:   d = {a, 11'h000} ^ 32'hC3A5_0F1E;
    endcase
    return d;
  endfunction

  assign rdata_a = slave_fn(addr_a);
  assign rdata_b = slave_fn(addr_b);

  fpro_mmio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt_a), .m0_rd_data(m0_rd_data_a), .m0_rd_valid(m0_rd_valid_a),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt_a), .m1_rd_data(m1_rd_data_a), .m1_rd_valid(m1_rd_valid_a),
    .fp_mmio_cs(cs_a), .fp_rd(rd_a), .fp_wr(wr_a), .fp_addr(addr_a),
    .fp_wr_data(wdata_a), .fp_rd_data(rdata_a)
  );

  fpro_mmio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt_b), .m0_rd_data(m0_rd_data_b), .m0_rd_valid(m0_rd_valid_b),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt_b), .m1_rd_data(m1_rd_data_b), .m1_rd_valid(m1_rd_valid_b),
    .fp_mmio_cs(cs_b), .fp_rd(rd_b), .fp_wr(wr_b), .fp_addr(addr_b),
    .fp_wr_data(wdata_b), .fp_rd_data(rdata_b)
  );

  // Collects cycles where both grants or both read-valids are high.
  always begin
    @(posedge clk);
    #2;
    if ((m0_gnt_a && m1_gnt_a) || (m0_rd_valid_a && m1_rd_valid_a) ||
        (m0_gnt_b && m1_gnt_b) || (m0_rd_valid_b && m1_rd_valid_b)) begin
      onehot_viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    m0_req  = 1'b0;
    m1_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m1_gnt_a, m0_gnt_a, m1_rd_valid_a, m0_rd_valid_a, cs_a, rd_a, wr_a} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes_a: got %b expected 0",
               {m1_gnt_a, m0_gnt_a, m1_rd_valid_a, m0_rd_valid_a, cs_a, rd_a, wr_a});
    end
    checks++;
    if ({addr_a, wdata_a} !== {(AW+DW){1'b0}}) begin
      errors++;
      $display("FAIL reset_bus_a: got addr %h data %h expected 0", addr_a, wdata_a);
    end
    checks++;
    if ({m1_rd_data_a, m0_rd_data_a} !== {(2*DW){1'b0}}) begin
      errors++;
      $display("FAIL reset_rd_data_a: got %h %h expected 0", m1_rd_data_a, m0_rd_data_a);
    end
    checks++;
    if ({m1_gnt_b, m0_gnt_b, m1_rd_valid_b, m0_rd_valid_b, cs_b, rd_b, wr_b} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes_b: got %b expected 0",
               {m1_gnt_b, m0_gnt_b, m1_rd_valid_b, m0_rd_valid_b, cs_b, rd_b, wr_b});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_gnt_a, m0_gnt_a, cs_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_a: got %b expected 000", {m1_gnt_a, m0_gnt_a, cs_a});
    end
  endtask

  task automatic test_m0_write();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00010; m0_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({m1_gnt_a, m0_gnt_a} !== 2'b01) begin
      errors++; $display("FAIL m0_write_gnt: got %b expected 01", {m1_gnt_a, m0_gnt_a});
    end
    checks++;
    if ({cs_a, rd_a, wr_a} !== 3'b101) begin
      errors++; $display("FAIL m0_write_strobes: got %b expected 101", {cs_a, rd_a, wr_a});
    end
    checks++;
    if (addr_a !== 21'h00010 || wdata_a !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL m0_write_bus: got %h/%h expected 00010/deadbeef", addr_a, wdata_a);
    end
    checks++;
    if ({cs_b, wr_b, addr_b, wdata_b} !== {1'b1, 1'b1, 21'h00010, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL m0_write_bus_b: got cs %b wr %b %h/%h", cs_b, wr_b, addr_b, wdata_b);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_a, rd_a, wr_a, m1_gnt_a, m0_gnt_a, m1_rd_valid_a, m0_rd_valid_a} !== 7'b0) begin
      errors++;
      $display("FAIL m0_write_done: got %b expected 0",
               {cs_a, rd_a, wr_a, m1_gnt_a, m0_gnt_a, m1_rd_valid_a, m0_rd_valid_a});
    end
    @(negedge clk);
    checks++;
    if (m0_rd_valid_a !== 1'b0 || m0_rd_data_a !== 32'h0 || addr_a !== 21'h00010) begin
      errors++;
      $display("FAIL m0_write_after: got valid %b data %h addr %h expected 0/0/00010",
               m0_rd_valid_a, m0_rd_data_a, addr_a);
    end
  endtask

  task automatic test_m1_read();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00020; m1_wr_data = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if ({m1_gnt_a, m0_gnt_a, cs_a, rd_a, wr_a} !== 5'b10110 || addr_a !== 21'h00020) begin
      errors++;
      $display("FAIL m1_read_issue: got gnt/strb %b addr %h expected 10110 00020",
               {m1_gnt_a, m0_gnt_a, cs_a, rd_a, wr_a}, addr_a);
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_rd_valid_a, m0_rd_valid_a} !== 2'b10) begin
      errors++; $display("FAIL m1_read_valid: got %b expected 10", {m1_rd_valid_a, m0_rd_valid_a});
    end
    checks++;
    if (m1_rd_data_a !== 32'h1234_5678) begin
      errors++; $display("FAIL m1_read_data: got %h expected 12345678", m1_rd_data_a);
    end
    checks++;
    if (m0_rd_data_a !== 32'h0 || m1_rd_data_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL m1_read_other: got m0 %h b.m1 %h expected 0/12345678", m0_rd_data_a, m1_rd_data_b);
    end
    @(negedge clk);
    checks++;
    if (m1_rd_valid_a !== 1'b0 || m1_rd_data_a !== 32'h1234_5678) begin
      errors++;
      $display("FAIL m1_read_hold: got valid %b data %h expected 0/12345678", m1_rd_valid_a, m1_rd_data_a);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00001; m0_wr_data = 32'h1111_1111;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00002;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_g = 2'b00;
      if ((i - 1) % 3 == 0) exp_g = (((i - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if ({m1_gnt_a, m0_gnt_a} !== exp_g || cs_a !== (exp_g != 2'b00)) begin
        errors++;
        $display("FAIL rr_cycle%0d: got gnt %b cs %b expected gnt %b", i,
                 {m1_gnt_a, m0_gnt_a}, cs_a, exp_g);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    logic [1:0] exp_g;
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00003;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00004;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_g = 2'b00;
      if (i == 1 || i == 4 || i == 7) exp_g = 2'b01;
      if (i == 10) exp_g = 2'b10;
      checks++;
      if ({m1_gnt_b, m0_gnt_b} !== exp_g) begin
        errors++;
        $display("FAIL fixed_cycle%0d: got %b expected %b", i, {m1_gnt_b, m0_gnt_b}, exp_g);
      end
      if (i == 7) m0_req = 1'b0;
      if (i == 10) m1_req = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00040;
    @(negedge clk);
    m0_req = 1'b0;
    repeat (2) @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00030;
    @(negedge clk);
    checks++;
    if ({cs_a, rd_a, wr_a, m0_gnt_a} !== 4'b1101) begin
      errors++; $display("FAIL rstmid_issue: got %b expected 1101", {cs_a, rd_a, wr_a, m0_gnt_a});
    end
    m0_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cs_a, rd_a, wr_a, m1_gnt_a, m0_gnt_a} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected 0", {cs_a, rd_a, wr_a, m1_gnt_a, m0_gnt_a});
    end
    @(negedge clk);
    checks++;
    if ({m1_rd_valid_a, m0_rd_valid_a} !== 2'b00 || m0_rd_data_a !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_novalid: got valid %b data %h expected 00/0",
               {m1_rd_valid_a, m0_rd_valid_a}, m0_rd_data_a);
    end
    reset_n = 1'b1;
    m0_req = 1'b1; m0_addr = 21'h00031;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00032;
    @(negedge clk);
    checks++;
    if ({m1_gnt_a, m0_gnt_a} !== 2'b01) begin
      errors++; $display("FAIL rstmid_first: got %b expected 01", {m1_gnt_a, m0_gnt_a});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_v;
    logic [DW-1:0] exp_d;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00005;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_v = (i == 2 || i == 5) ? 2'b01 : 2'b00;
      exp_d = (i == 2) ? 32'h0000_000A : 32'h0000_000B;
      checks++;
      if ({m1_rd_valid_a, m0_rd_valid_a} !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid%0d: got %b expected %b", i, {m1_rd_valid_a, m0_rd_valid_a}, exp_v);
      end
      if (exp_v == 2'b01) begin
        checks++;
        if (m0_rd_data_a !== exp_d) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, m0_rd_data_a, exp_d);
        end
      end
      if (i == 1) m0_addr = 21'h00006;
      if (i == 4) m0_req = 1'b0;
    end
    checks++;
    if (onehot_viol !== 0) begin
      errors++; $display("FAIL onehot_b2b: got %0d violations expected 0", onehot_viol);
    end
  endtask

  // Random traffic against a transaction-level model: a grant appears the
  // cycle after an eligible request, the bus is busy for three cycles per
  // access, and read data returns the cycle after the grant.
  task automatic test_random();
    int            free_c;
    int            w;
    logic          model_last;
    logic [1:0]    exp_gnt, exp_valid, pv_mask;
    logic [2:0]    exp_strb;
    logic [AW-1:0] exp_addr, sel_addr;
    logic [DW-1:0] exp_wdata, pv_data, sel_data;
    logic [DW-1:0] exp_rd [2];
    logic          sel_wr;
    do_reset();
    free_c = 1; model_last = 1'b1;
    exp_gnt = 2'b00; exp_valid = 2'b00; pv_mask = 2'b00; exp_strb = 3'b000;
    exp_addr = '0; exp_wdata = '0; pv_data = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int k = 0; k <= 240; k++) begin
      if (k > 0) begin
        @(negedge clk);
        checks++;
        if ({m1_gnt_a, m0_gnt_a} !== exp_gnt) begin
          errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", k, {m1_gnt_a, m0_gnt_a}, exp_gnt);
        end
        checks++;
        if ({cs_a, rd_a, wr_a} !== exp_strb) begin
          errors++; $display("FAIL rnd_strb@%0d: got %b expected %b", k, {cs_a, rd_a, wr_a}, exp_strb);
        end
        checks++;
        if (addr_a !== exp_addr || wdata_a !== exp_wdata) begin
          errors++;
          $display("FAIL rnd_bus@%0d: got %h/%h expected %h/%h", k, addr_a, wdata_a, exp_addr, exp_wdata);
        end
        checks++;
        if ({m1_rd_valid_a, m0_rd_valid_a} !== exp_valid) begin
          errors++;
          $display("FAIL rnd_valid@%0d: got %b expected %b", k, {m1_rd_valid_a, m0_rd_valid_a}, exp_valid);
        end
        checks++;
        if (m0_rd_data_a !== exp_rd[0] || m1_rd_data_a !== exp_rd[1]) begin
          errors++;
          $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", k,
                   m0_rd_data_a, m1_rd_data_a, exp_rd[0], exp_rd[1]);
        end
      end
      if (exp_gnt[0]) begin
        m0_req = 1'b0;
      end else if (!m0_req && ($urandom_range(0, 3) == 0)) begin
        m0_req = 1'b1; m0_wr = 1'($urandom_range(0, 1));
        m0_addr = 21'($urandom_range(0, 63)); m0_wr_data = $urandom;
      end
      if (exp_gnt[1]) begin
        m1_req = 1'b0;
      end else if (!m1_req && ($urandom_range(0, 3) == 0)) begin
        m1_req = 1'b1; m1_wr = 1'($urandom_range(0, 1));
        m1_addr = 21'($urandom_range(0, 63)); m1_wr_data = $urandom;
      end
      exp_valid = pv_mask;
      if (pv_mask[0]) exp_rd[0] = pv_data;
      if (pv_mask[1]) exp_rd[1] = pv_data;
      pv_mask = 2'b00; exp_gnt = 2'b00; exp_strb = 3'b000;
      if ((k + 1 >= free_c) && (m0_req || m1_req)) begin
        if (m0_req && m1_req) w = model_last ? 0 : 1;
        else w = m1_req ? 1 : 0;
        if (w == 1) begin
          sel_wr = m1_wr; sel_addr = m1_addr; sel_data = m1_wr_data;
        end else begin
          sel_wr = m0_wr; sel_addr = m0_addr; sel_data = m0_wr_data;
        end
        exp_gnt[w] = 1'b1;
        exp_strb   = {1'b1, ~sel_wr, sel_wr};
        exp_addr   = sel_addr;
        exp_wdata  = sel_data;
        model_last = (w == 1);
        free_c     = k + 4;
        if (!sel_wr) begin
          pv_mask[w] = 1'b1;
          pv_data    = slave_fn(sel_addr);
        end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (onehot_viol !== 0) begin
      errors++; $display("FAIL onehot_random: got %0d violations expected 0", onehot_viol);
    end
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
